// File: rtl/tdm_demux8.sv
// ---------------------------------------------------------------------------
// tdm_demux8 : receive end of the 8-channel time-division link.
//
// Samples one serial bit per slot strobe, aligns to the frame sync marker
// carried on slot 0, collects the eight slots of a frame in a shadow
// register and presents them together on o once the frame is complete.
//
// Parameters
//   SYNC_CHECK  1: a missing sync on slot 0 while locked is an error and
//                  forces a re-hunt.  0: sync only (re)aligns the frame.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           in   slot strobe; din/sync are sampled only when en=1
//   din          in   serial data bit of the current slot
//   sync         in   frame marker, high with en on the slot-0 bit
//   o[7:0]       out  registered channels, o[0]=channel a ... o[7]=channel h
//   frame_valid  out  one-cycle pulse, o was just loaded with a full frame
//   slot[2:0]    out  slot index the next strobe will write
//   locked       out  high while frame alignment is held
//   sync_err     out  one-cycle pulse on an alignment error
// ---------------------------------------------------------------------------
module tdm_demux8 #(
    parameter int SYNC_CHECK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       sync,
    output logic [7:0] o,
    output logic       frame_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] o_q, o_d;
    logic       fv_q, fv_d;
    logic       err_q, err_d;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        o_d      = o_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;

        if (en) begin
            if (state_q == HUNT) begin
                // Bits are thrown away until a sync marks slot 0.
                if (sync) begin
                    shadow_d = {7'd0, din};
                    slot_d   = 3'd1;
                    state_d  = LOCKED;
                end
            end else begin
                if (sync && (slot_q != 3'd0)) begin
                    // Early sync: drop the partial frame and restart on this bit.
                    err_d    = 1'b1;
                    shadow_d = {7'd0, din};
                    slot_d   = 3'd1;
                end else if (!sync && (slot_q == 3'd0) && (SYNC_CHECK != 0)) begin
                    // Missing sync: alignment is no longer trusted.
                    err_d   = 1'b1;
                    state_d = HUNT;
                    slot_d  = 3'd0;
                end else begin
                    shadow_d[slot_q] = din;
                    slot_d           = slot_q + 3'd1;
                    // The slot-7 bit completes the frame; o is loaded in one
                    // go so it is never seen partially updated.
                    if (slot_q == 3'd7) begin
                        o_d  = shadow_d;
                        fv_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= 3'd0;
            shadow_q <= 8'h00;
            o_q      <= 8'h00;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            o_q      <= o_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    assign o           = o_q;
    assign frame_valid = fv_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
module tb_tdm_demux8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic din = 1'b0;
    logic sync = 1'b0;

    logic [7:0] o1, o0;
    logic       fv1, fv0, lk1, lk0, er1, er0;
    logic [2:0] sl1, sl0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tdm_demux8 #(.SYNC_CHECK(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .o(o1), .frame_valid(fv1), .slot(sl1), .locked(lk1), .sync_err(er1)
    );

    tdm_demux8 #(.SYNC_CHECK(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .o(o0), .frame_valid(fv0), .slot(sl0), .locked(lk0), .sync_err(er0)
    );

    typedef struct {
        bit         rst;
        bit         en;
        bit         din;
        bit         sync;
        logic [7:0] o;
        bit         fv;
        logic [2:0] slot;
        bit         lk;
        bit         err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [7:0] e_o, input bit e_fv,
                        input logic [2:0] e_sl, input bit e_lk, input bit e_er);
        chk({tag, " sc1.o"},      o1,          e_o);
        chk({tag, " sc1.fv"},     {7'd0, fv1}, {7'd0, e_fv});
        chk({tag, " sc1.slot"},   {5'd0, sl1}, {5'd0, e_sl});
        chk({tag, " sc1.locked"}, {7'd0, lk1}, {7'd0, e_lk});
        chk({tag, " sc1.err"},    {7'd0, er1}, {7'd0, e_er});
    endtask

    task automatic chk0(input string tag, input logic [7:0] e_o, input bit e_fv,
                        input logic [2:0] e_sl, input bit e_lk, input bit e_er);
        chk({tag, " sc0.o"},      o0,          e_o);
        chk({tag, " sc0.fv"},     {7'd0, fv0}, {7'd0, e_fv});
        chk({tag, " sc0.slot"},   {5'd0, sl0}, {5'd0, e_sl});
        chk({tag, " sc0.locked"}, {7'd0, lk0}, {7'd0, e_lk});
        chk({tag, " sc0.err"},    {7'd0, er0}, {7'd0, e_er});
    endtask

    task automatic step(input bit e, input bit d, input bit s);
        @(negedge clk);
        en = e; din = d; sync = s;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic pulse_reset();
        @(negedge clk);
        en = 1'b0; sync = 1'b0; din = 1'b0;
        #2 rst = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(input bit r, input bit e, input bit d, input bit s,
                       input logic [7:0] eo, input bit efv, input logic [2:0] esl,
                       input bit elk, input bit eer);
        vec_t v;
        v.rst = r; v.en = e; v.din = d; v.sync = s;
        v.o = eo; v.fv = efv; v.slot = esl; v.lk = elk; v.err = eer;
        vq.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            string t;
            t = $sformatf("%s[%0d]", tag, i);
            if (vq[i].rst) begin
                pulse_reset();
                chk1(t, vq[i].o, vq[i].fv, vq[i].slot, vq[i].lk, vq[i].err);
                chk0(t, vq[i].o, vq[i].fv, vq[i].slot, vq[i].lk, vq[i].err);
                release_reset();
            end else begin
                step(vq[i].en, vq[i].din, vq[i].sync);
                chk1(t, vq[i].o, vq[i].fv, vq[i].slot, vq[i].lk, vq[i].err);
                chk0(t, vq[i].o, vq[i].fv, vq[i].slot, vq[i].lk, vq[i].err);
            end
        end
        vq.delete();
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] miss;
        int fv_count;
        a5 = 8'hA5;

        // Reset, then frame A5 with en held high.
        add(1, 0, 0, 0, 8'h00, 0, 3'd0, 0, 0);
        add(0, 1, 1, 1, 8'h00, 0, 3'd1, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 3'd2, 1, 0);
        add(0, 1, 1, 0, 8'h00, 0, 3'd3, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 3'd4, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 3'd5, 1, 0);
        add(0, 1, 1, 0, 8'h00, 0, 3'd6, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 3'd7, 1, 0);
        add(0, 1, 1, 0, 8'hA5, 1, 3'd0, 1, 0);
        // sync without en is ignored, o holds.
        add(0, 0, 0, 1, 8'hA5, 0, 3'd0, 1, 0);
        // Early sync at slot 4, then the rest of frame 81.
        add(0, 1, 1, 1, 8'hA5, 0, 3'd1, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 0, 3'd2, 1, 0);
        add(0, 1, 1, 0, 8'hA5, 0, 3'd3, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 0, 3'd4, 1, 0);
        add(0, 1, 1, 1, 8'hA5, 0, 3'd1, 1, 1);
        add(0, 1, 0, 0, 8'hA5, 0, 3'd2, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 0, 3'd3, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 0, 3'd4, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 0, 3'd5, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 0, 3'd6, 1, 0);
        add(0, 1, 0, 0, 8'hA5, 0, 3'd7, 1, 0);
        add(0, 1, 1, 0, 8'h81, 1, 3'd0, 1, 0);
        // Back-to-back frame 5A: next pulse exactly 8 cycles later.
        add(0, 1, 0, 1, 8'h81, 0, 3'd1, 1, 0);
        add(0, 1, 1, 0, 8'h81, 0, 3'd2, 1, 0);
        add(0, 1, 0, 0, 8'h81, 0, 3'd3, 1, 0);
        add(0, 1, 1, 0, 8'h81, 0, 3'd4, 1, 0);
        add(0, 1, 1, 0, 8'h81, 0, 3'd5, 1, 0);
        add(0, 1, 0, 0, 8'h81, 0, 3'd6, 1, 0);
        add(0, 1, 1, 0, 8'h81, 0, 3'd7, 1, 0);
        add(0, 1, 0, 0, 8'h5A, 1, 3'd0, 1, 0);
        run_table("basic");

        // Missing sync at slot 0: SYNC_CHECK=1 re-hunts, SYNC_CHECK=0 keeps going.
        step(1, 1, 0);
        chk1("miss0", 8'h5A, 0, 3'd0, 0, 1);
        chk0("miss0", 8'h5A, 0, 3'd1, 1, 0);
        miss = 8'h7F;
        for (int i = 1; i < 8; i++) begin
            step(1, miss[i], 0);
            chk1($sformatf("miss%0d", i), 8'h5A, 0, 3'd0, 0, 0);
            if (i < 7) chk0($sformatf("miss%0d", i), 8'h5A, 0, 3'(i + 1), 1, 0);
            else       chk0("miss7", 8'h7F, 1, 3'd0, 1, 0);
        end

        // HUNT rejection: five unsynced strobes, then frame 3C.
        add(1, 0, 0, 0, 8'h00, 0, 3'd0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 8'h00, 0, 3'd0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 0, 3'd1, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 3'd2, 1, 0);
        add(0, 1, 1, 0, 8'h00, 0, 3'd3, 1, 0);
        add(0, 1, 1, 0, 8'h00, 0, 3'd4, 1, 0);
        add(0, 1, 1, 0, 8'h00, 0, 3'd5, 1, 0);
        add(0, 1, 1, 0, 8'h00, 0, 3'd6, 1, 0);
        add(0, 1, 0, 0, 8'h00, 0, 3'd7, 1, 0);
        add(0, 1, 0, 0, 8'h3C, 1, 3'd0, 1, 0);
        run_table("hunt");

        // Strobe gaps: en only every third cycle, with sync/din toggling in the gaps.
        pulse_reset();
        release_reset();
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 2; g++) begin
                step(0, ~a5[i], 1);
                chk1($sformatf("gap%0d.%0d", i, g), 8'h00, 0, 3'(i), (i != 0), 0);
            end
            step(1, a5[i], (i == 0));
            if (i < 7) chk1($sformatf("gapstb%0d", i), 8'h00, 0, 3'(i + 1), 1, 0);
            else       chk0("gapstb7", 8'hA5, 1, 3'd0, 1, 0);
        end
        step(0, 0, 0);
        chk1("gaphold", 8'hA5, 0, 3'd0, 1, 0);

        // Async reset mid-frame at slot 5.
        for (int i = 0; i < 5; i++) step(1, 1, (i == 0));
        chk1("pre_rst", 8'hA5, 0, 3'd5, 1, 0);
        pulse_reset();
        chk1("async_rst", 8'h00, 0, 3'd0, 0, 0);
        chk0("async_rst", 8'h00, 0, 3'd0, 0, 0);
        release_reset();
        fv_count = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0);
            if (fv1 || fv0) fv_count++;
            chk1($sformatf("post_rst%0d", i), 8'h00, 0, 3'd0, 0, 0);
        end
        chk("post_rst.fv_count", 8'(fv_count), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
